// File: rtl/fft_pair_unloader_if.sv
// Pair bus into the FFT unloader and natural-order complex stream out of it.
// Optional o_index (bin number of the current beat) exists only when
// UNLOADER_INDEX_EN is defined.
interface fft_pair_unloader_if #(
   parameter int DATA_W = 32
`ifdef UNLOADER_INDEX_EN
  ,parameter int ADDR_W = 10
`endif
);
   logic              i_valid_in;
   logic [DATA_W-1:0] i_data_a_real;
   logic [DATA_W-1:0] i_data_a_imag;
   logic [DATA_W-1:0] i_data_b_real;
   logic [DATA_W-1:0] i_data_b_imag;
   logic              i_ready;
   logic              i_ovf_clear;
   logic              o_valid;
   logic [DATA_W-1:0] o_data_real;
   logic [DATA_W-1:0] o_data_imag;
   logic              o_last;
   logic              o_overflow;
`ifdef UNLOADER_INDEX_EN
   logic [ADDR_W-1:0] o_index;
`endif

   // Unloader side
   modport slave (
      input  i_valid_in, i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag,
      input  i_ready, i_ovf_clear,
      output o_valid, o_data_real, o_data_imag, o_last, o_overflow
`ifdef UNLOADER_INDEX_EN
     ,output o_index
`endif
   );

   // Producer / sink side
   modport master (
      output i_valid_in, i_data_a_real, i_data_a_imag, i_data_b_real, i_data_b_imag,
      output i_ready, i_ovf_clear,
      input  o_valid, o_data_real, o_data_imag, o_last, o_overflow
`ifdef UNLOADER_INDEX_EN
     ,input  o_index
`endif
   );
endinterface

// File: rtl/fft_pair_unloader.sv
// FFT pair unloader: buffers (X[k], X[k+N/2]) pairs into a ping-pong RAM and
// streams each frame out in natural order with a valid/ready handshake.
// A frame that completes while the read bank is still draining is dropped and
// flagged on the sticky o_overflow.
// Define UNLOADER_INDEX_EN to drive o_index (bin number of the current beat).
module fft_pair_unloader #(
   parameter int DATA_W    = 32,
   parameter int FRAME_LEN = 1024
) (
   input logic           i_clk,
   input logic           i_reset,
   fft_pair_unloader_if.slave bus
);
   localparam int ADDR_W = $clog2(FRAME_LEN);
   localparam int HALF   = FRAME_LEN / 2;
   localparam int CNT_W  = ADDR_W - 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

   typedef enum logic [1:0] {IDLE, PRIME, STREAM} state_t;

   // Each bank is split into a low half (a = X[k]) and high half (b = X[k+N/2])
   // so both samples of a pair land in one cycle with one write port per half.
   logic [2*DATA_W-1:0] mem_lo [2][HALF];
   logic [2*DATA_W-1:0] mem_hi [2][HALF];

   state_t              state_q, state_d;
   logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
   logic                wr_bank_q, wr_bank_d;
   logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
   logic                valid_q, valid_d;
   logic                last_q, last_d;
   logic [DATA_W-1:0]   real_q, real_d;
   logic [DATA_W-1:0]   imag_q, imag_d;
   logic                ovf_q, ovf_d;

   logic                xfer, frame_done, swap, rd_bank;
   logic [ADDR_W-1:0]   rd_addr_nxt;
   logic [2*DATA_W-1:0] rd_word;

   // Write side: store the pair into the current write bank
   always_ff @(posedge i_clk) begin
      if (bus.i_valid_in) begin
         mem_lo[wr_bank_q][wr_cnt_q] <= {bus.i_data_a_real, bus.i_data_a_imag};
         mem_hi[wr_bank_q][wr_cnt_q] <= {bus.i_data_b_real, bus.i_data_b_imag};
      end
   end

   // Next-state logic: pair counting, bank swap / drop, read sequencing
   always_comb begin
      xfer        = valid_q & bus.i_ready;
      frame_done  = bus.i_valid_in & (wr_cnt_q == '1);
      // Swap only if nothing is being read, or the final beat leaves this cycle
      swap        = frame_done & ((state_q == IDLE) | (xfer & last_q));
      rd_bank     = ~wr_bank_q;
      rd_addr_nxt = (state_q == PRIME) ? '0 : rd_addr_q + 1'b1;
      // The output register doubles as the RAM read register; it only loads
      // on PRIME or a transfer, so a stall simply holds the current beat.
      rd_word     = rd_addr_nxt[ADDR_W-1] ? mem_hi[rd_bank][rd_addr_nxt[CNT_W-1:0]]
                                          : mem_lo[rd_bank][rd_addr_nxt[CNT_W-1:0]];

      state_d   = state_q;
      wr_cnt_d  = wr_cnt_q + CNT_W'(bus.i_valid_in);
      wr_bank_d = swap ? ~wr_bank_q : wr_bank_q;
      rd_addr_d = rd_addr_q;
      valid_d   = valid_q;
      last_d    = last_q;
      real_d    = real_q;
      imag_d    = imag_q;
      ovf_d     = ovf_q;

      // Set beats clear when both happen together
      if (bus.i_ovf_clear)     ovf_d = 1'b0;
      if (frame_done && !swap) ovf_d = 1'b1;

      case (state_q)
         IDLE: if (swap) state_d = PRIME;
         PRIME: begin
            state_d   = STREAM;
            valid_d   = 1'b1;
            rd_addr_d = '0;
            last_d    = 1'b0;
            {real_d, imag_d} = rd_word;
         end
         STREAM: if (xfer) begin
            if (last_q) begin
               valid_d = 1'b0;
               last_d  = 1'b0;
               state_d = swap ? PRIME : IDLE;
            end else begin
               rd_addr_d = rd_addr_nxt;
               last_d    = (rd_addr_nxt == LAST_ADDR);
               {real_d, imag_d} = rd_word;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and output registers
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q   <= IDLE;
         wr_cnt_q  <= '0;
         wr_bank_q <= 1'b0;
         rd_addr_q <= '0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
         real_q    <= '0;
         imag_q    <= '0;
         ovf_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_cnt_q  <= wr_cnt_d;
         wr_bank_q <= wr_bank_d;
         rd_addr_q <= rd_addr_d;
         valid_q   <= valid_d;
         last_q    <= last_d;
         real_q    <= real_d;
         imag_q    <= imag_d;
         ovf_q     <= ovf_d;
      end
   end

   assign bus.o_valid     = valid_q;
   assign bus.o_data_real = real_q;
   assign bus.o_data_imag = imag_q;
   assign bus.o_last      = last_q;
   assign bus.o_overflow  = ovf_q;
`ifdef UNLOADER_INDEX_EN
   // Read address register already tracks the bin of the held beat
   assign bus.o_index     = rd_addr_q;
`endif
endmodule

// File: tb/tb_fft_pair_unloader.sv
// Directed bench for fft_pair_unloader (FRAME_LEN=8): scoreboard of expected
// natural-order beats, stall-stability monitor, latency / overflow / reset steps.
module tb_fft_pair_unloader;
   localparam int DATA_W    = 32;
   localparam int FRAME_LEN = 8;
   localparam int ADDR_W    = 3;
   localparam int HALF      = FRAME_LEN / 2;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   fft_pair_unloader_if #(.DATA_W(DATA_W)
`ifdef UNLOADER_INDEX_EN
     ,.ADDR_W(ADDR_W)
`endif
   ) bus ();

   fft_pair_unloader #(.DATA_W(DATA_W), .FRAME_LEN(FRAME_LEN)) dut (
      .i_clk  (clk),
      .i_reset(rst),
      .bus    (bus)
   );

   typedef struct packed {
      logic [DATA_W-1:0] re;
      logic [DATA_W-1:0] im;
      logic              last;
      logic [ADDR_W-1:0] idx;
   } beat_t;

   beat_t sb[$];
   int checks = 0;
   int errors = 0;
   int rdy_mode = 0;   // 0: always ready, 1: 1,0,0,1,0,1 pattern, 2: never ready
   int rdy_cnt = 0;
   logic [5:0] rdy_pat = 6'b101001;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Downstream ready driver
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: bus.i_ready = 1'b1;
         1: begin bus.i_ready = rdy_pat[rdy_cnt % 6]; rdy_cnt++; end
         default: bus.i_ready = 1'b0;
      endcase
   end

   // Output monitor: scoreboard pops on transfer, stability under stall
   logic              pv, pr, pl;
   logic [63:0]       pd;
   always @(negedge clk) begin
      if (rst) begin
         pv = 1'b0; pr = 1'b0;
      end else begin
         if (pv && !pr) begin
            chk("stall_valid", 64'(bus.o_valid), 64'd1);
            chk("stall_data", {bus.o_data_real, bus.o_data_imag}, pd);
            chk("stall_last", 64'(bus.o_last), 64'(pl));
         end
         if (bus.o_valid && bus.i_ready) begin
            chk("beat_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
               beat_t e;
               e = sb.pop_front();
               chk("beat_real", 64'(bus.o_data_real), 64'(e.re));
               chk("beat_imag", 64'(bus.o_data_imag), 64'(e.im));
               chk("beat_last", 64'(bus.o_last), 64'(e.last));
`ifdef UNLOADER_INDEX_EN
               chk("beat_index", 64'(bus.o_index), 64'(e.idx));
`endif
            end
         end
         pv = bus.o_valid; pr = bus.i_ready; pl = bus.o_last;
         pd = {bus.o_data_real, bus.o_data_imag};
      end
   end

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; bus.i_valid_in = 1'b0; end
   endtask

   task automatic send_pair(input int k, input int base);
      int va, vb;
      va = base + k;
      vb = base + k + HALF;
      @(posedge clk); #1;
      bus.i_valid_in    = 1'b1;
      bus.i_data_a_real = DATA_W'(va);
      bus.i_data_a_imag = DATA_W'(-va);
      bus.i_data_b_real = DATA_W'(vb);
      bus.i_data_b_imag = DATA_W'(-vb);
   endtask

   task automatic push_frame(input int base);
      for (int n = 0; n < FRAME_LEN; n++) begin
         beat_t e;
         e.re = DATA_W'(base + n);
         e.im = DATA_W'(-(base + n));
         e.last = (n == FRAME_LEN - 1);
         e.idx = ADDR_W'(n);
         sb.push_back(e);
      end
   endtask

   // Leaves valid asserted on the last pair; caller decides what follows
   task automatic send_frame(input int base, input int maxgap);
      for (int k = 0; k < HALF; k++) begin
         send_pair(k, base);
         if (maxgap > 0 && k < HALF - 1) idle($urandom_range(maxgap, 0));
      end
   endtask

   task automatic wait_drain();
      int t;
      t = 0;
      while (sb.size() != 0 && t < 300) begin @(posedge clk); #1; bus.i_valid_in = 1'b0; t++; end
      chk("drain_empty", 64'(sb.size()), 64'd0);
      idle(3);
   endtask

   task automatic check_outputs_zero(input string tag);
      chk({tag, "_valid"}, 64'(bus.o_valid), 64'd0);
      chk({tag, "_data"}, {bus.o_data_real, bus.o_data_imag}, 64'd0);
      chk({tag, "_last"}, 64'(bus.o_last), 64'd0);
      chk({tag, "_ovf"}, 64'(bus.o_overflow), 64'd0);
`ifdef UNLOADER_INDEX_EN
      chk({tag, "_index"}, 64'(bus.o_index), 64'd0);
`endif
   endtask

   initial begin
      rst = 1'b1;
      bus.i_valid_in = 1'b0;
      bus.i_data_a_real = '0; bus.i_data_a_imag = '0;
      bus.i_data_b_real = '0; bus.i_data_b_imag = '0;
      bus.i_ovf_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1 check_outputs_zero("reset");
      @(posedge clk); #1 rst = 1'b0;

      // Single frame, always ready, with latency check
      rdy_mode = 0;
      push_frame(0);
      send_frame(0, 0);
      idle(1);
      chk("lat_prime_valid", 64'(bus.o_valid), 64'd0);
      idle(1);
      chk("lat_first_valid", 64'(bus.o_valid), 64'd1);
      chk("lat_first_real", 64'(bus.o_data_real), 64'd0);
      wait_drain();

      // Same frame under a stalling sink
      rdy_mode = 1;
      push_frame(0);
      send_frame(0, 0);
      wait_drain();
      rdy_mode = 0;
      idle(2);

      // Three frames, each timed so its last pair lands on the final beat of
      // the previous frame (input runs at 2 samples/cycle, output at 1)
      push_frame(10); push_frame(20); push_frame(30);
      send_frame(10, 0);
      idle(5);
      send_frame(20, 0);
      idle(1);
      chk("swap_prime_bubble", 64'(bus.o_valid), 64'd0);
      idle(1);
      chk("swap_stream", 64'(bus.o_valid), 64'd1);
      chk("swap_first_real", 64'(bus.o_data_real), 64'd20);
      idle(3);
      send_frame(30, 0);
      wait_drain();
      chk("b2b_overflow", 64'(bus.o_overflow), 64'd0);

      // Overflow: two frames into a blocked sink
      rdy_mode = 2;
      idle(2);
      push_frame(100);
      send_frame(100, 0);
      send_frame(200, 0);
      idle(2);
      chk("ovf_set", 64'(bus.o_overflow), 64'd1);
      chk("ovf_held_valid", 64'(bus.o_valid), 64'd1);
      chk("ovf_held_real", 64'(bus.o_data_real), 64'd100);
      chk("ovf_pending", 64'(sb.size()), 64'd8);
      rdy_mode = 0;
      wait_drain();
      push_frame(300);
      send_frame(300, 0);
      wait_drain();
      chk("ovf_sticky", 64'(bus.o_overflow), 64'd1);
      @(posedge clk); #1 bus.i_ovf_clear = 1'b1;
      @(posedge clk); #1 bus.i_ovf_clear = 1'b0;
      chk("ovf_cleared", 64'(bus.o_overflow), 64'd0);

      // Gaps of 0..3 cycles between pairs
      push_frame(400);
      send_frame(400, 3);
      wait_drain();

      // Reset after pair 2 of a frame, then a clean frame
      for (int k = 0; k < 3; k++) send_pair(k, 500);
      idle(1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_outputs_zero("mid_reset");
      @(posedge clk); #1 rst = 1'b0;
      push_frame(0);
      send_frame(0, 0);
      wait_drain();
      idle(5);
      chk("no_stale", 64'(sb.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
